// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: widths, opcode constants, field slices and operand-use decode.
package rv32i_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

    function automatic logic [OPC_W-1:0] get_opcode(input logic [XLEN-1:0] inst);
        return inst[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [REG_W-1:0] get_rd(input logic [XLEN-1:0] inst);
        return inst[RD_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] get_rs1(input logic [XLEN-1:0] inst);
        return inst[RS1_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] get_rs2(input logic [XLEN-1:0] inst);
        return inst[RS2_LSB +: REG_W];
    endfunction

    // Unknown opcodes are treated as reading rs1, so they stall conservatively.
    function automatic logic uses_rs1(input logic [OPC_W-1:0] opc);
        logic used;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: used = 1'b0;
            OPC_OP, OPC_OP_IMM, OPC_LOAD,
            OPC_STORE, OPC_BRANCH, OPC_JALR: used = 1'b1;
            default: used = 1'b1;
        endcase
        return used;
    endfunction

    function automatic logic uses_rs2(input logic [OPC_W-1:0] opc);
        logic used;
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: used = 1'b1;
            default: used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority forward select for one source operand: x0, then EX, then MA, then RF.
module operand_fwd_mux
    import rv32i_pkg::*;
(
    input  logic [REG_W-1:0] idx_i,
    input  logic             ex_wen_i,
    input  logic [REG_W-1:0] ex_wadr_i,
    input  logic [XLEN-1:0]  ex_wdata_i,
    input  logic             ma_wen_i,
    input  logic [REG_W-1:0] ma_wadr_i,
    input  logic [XLEN-1:0]  ma_wdata_i,
    input  logic [XLEN-1:0]  rf_rdata_i,
    output logic [XLEN-1:0]  data_c_o
);

    always_comb begin
        data_c_o = rf_rdata_i;
        if (idx_i == '0) begin
            data_c_o = '0;
        end else if (ex_wen_i && (ex_wadr_i == idx_i)) begin
            data_c_o = ex_wdata_i;
        end else if (ma_wen_i && (ma_wadr_i == idx_i)) begin
            data_c_o = ma_wdata_i;
        end
    end

endmodule

// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch: RF address drive, EX/MA forwarding, load-use stall
// and a registered valid/ready bundle towards EX.
module id_operand_fetch
    import rv32i_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_inst,
    input  logic [XLEN-1:0]  if_pc,
    output logic [REG_W-1:0] ram_radr1,
    output logic [REG_W-1:0] ram_radr2,
    input  logic [XLEN-1:0]  ram_rdata1,
    input  logic [XLEN-1:0]  ram_rdata2,
    input  logic             ex_fwd_wen,
    input  logic [REG_W-1:0] ex_fwd_wadr,
    input  logic [XLEN-1:0]  ex_fwd_wdata,
    input  logic             ex_fwd_load,
    input  logic             ma_fwd_wen,
    input  logic [REG_W-1:0] ma_fwd_wadr,
    input  logic [XLEN-1:0]  ma_fwd_wdata,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_inst,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data
);

    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_inst_q, ex_inst_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_rs1_q, ex_rs1_d;
    logic [XLEN-1:0] ex_rs2_q, ex_rs2_d;

    logic [REG_W-1:0] id_rs1_c, id_rs2_c;
    logic             rs1_hit_c, rs2_hit_c;
    logic             hazard_c, advance_c, accept_c, hold_c;
    logic [XLEN-1:0]  rs1_fwd_c, rs2_fwd_c;

    assign id_rs1_c  = get_rs1(id_inst_q);
    assign id_rs2_c  = get_rs2(id_inst_q);
    assign rs1_hit_c = uses_rs1(get_opcode(id_inst_q)) && (id_rs1_c == ex_fwd_wadr);
    assign rs2_hit_c = uses_rs2(get_opcode(id_inst_q)) && (id_rs2_c == ex_fwd_wadr);

    // A load in EX has no data yet; wait until it reaches MA.
    assign hazard_c  = id_valid_q && ex_fwd_load && ex_fwd_wen && (ex_fwd_wadr != '0)
                       && (rs1_hit_c || rs2_hit_c);
    assign advance_c = id_valid_q && !hazard_c && (!ex_valid_q || ex_ready) && !flush;
    assign if_ready  = !flush && (!id_valid_q || advance_c);
    assign accept_c  = if_valid && if_ready;

    // Re-present the held sources so the RF output stays aligned with ID across stalls.
    assign hold_c    = id_valid_q && !advance_c;
    assign ram_radr1 = hold_c ? id_rs1_c : get_rs1(if_inst);
    assign ram_radr2 = hold_c ? id_rs2_c : get_rs2(if_inst);

    operand_fwd_mux u_fwd_rs1 (
        .idx_i      (id_rs1_c),
        .ex_wen_i   (ex_fwd_wen),
        .ex_wadr_i  (ex_fwd_wadr),
        .ex_wdata_i (ex_fwd_wdata),
        .ma_wen_i   (ma_fwd_wen),
        .ma_wadr_i  (ma_fwd_wadr),
        .ma_wdata_i (ma_fwd_wdata),
        .rf_rdata_i (ram_rdata1),
        .data_c_o   (rs1_fwd_c)
    );

    operand_fwd_mux u_fwd_rs2 (
        .idx_i      (id_rs2_c),
        .ex_wen_i   (ex_fwd_wen),
        .ex_wadr_i  (ex_fwd_wadr),
        .ex_wdata_i (ex_fwd_wdata),
        .ma_wen_i   (ma_fwd_wen),
        .ma_wadr_i  (ma_fwd_wadr),
        .ma_wdata_i (ma_fwd_wdata),
        .rf_rdata_i (ram_rdata2),
        .data_c_o   (rs2_fwd_c)
    );

    always_comb begin
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        ex_valid_d = ex_valid_q;
        ex_inst_d  = ex_inst_q;
        ex_pc_d    = ex_pc_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;

        if (flush) begin
            id_valid_d = 1'b0;
            ex_valid_d = 1'b0;
        end else begin
            if (accept_c) begin
                id_valid_d = 1'b1;
                id_inst_d  = if_inst;
                id_pc_d    = if_pc;
            end else if (advance_c) begin
                id_valid_d = 1'b0;
            end

            if (advance_c) begin
                ex_valid_d = 1'b1;
                ex_inst_d  = id_inst_q;
                ex_pc_d    = id_pc_q;
                ex_rs1_d   = rs1_fwd_c;
                ex_rs2_d   = rs2_fwd_c;
            end else if (ex_valid_q && ex_ready) begin
                ex_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_inst_q  <= '0;
            ex_pc_q    <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            ex_valid_q <= ex_valid_d;
            ex_inst_q  <= ex_inst_d;
            ex_pc_q    <= ex_pc_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_inst     = ex_inst_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rs1_data = ex_rs1_q;
    assign ex_rs2_data = ex_rs2_q;

endmodule
